maskmul_share_codec: RTL and testbench

- Hardware counterpart of the random masked-stimulus bench for maskmul.
- Encode side: takes plaintext operands a and b, draws fresh masks ma, mb and mq from an internal LFSR, and drives the masked shares into the maskmul instance.
- Decode side: receives qm, unmasks it with the matching delayed mq, and emits plaintext q together with the aligned a and b.
- Keeps a per-value histogram of q, so on-chip runs give the same statistics as the simulated ones.

---
 rtl/maskmul_pkg.sv | 26 ++
 rtl/maskmul_lfsr.sv | 26 ++
 rtl/maskmul_share_codec.sv | 167 ++++++++++++++++
 tb/tb_maskmul_share_codec.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maskmul_pkg.sv
// Shared definitions for masked-multiplier codec blocks: widths, LFSR
// polynomial and seed, LFSR step and share unmasking helpers.
package maskmul_pkg;

  localparam int unsigned W_DEF  = 2;
  localparam int unsigned LFSR_W = 32;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_POLY     = 32'h80200003;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 32'hACE12461;

  // One right-shifting Galois step
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {1'b0, s[LFSR_W-1:1]};
    if (s[0]) n = n ^ LFSR_POLY;
    return n;
  endfunction

  // Remove the output mask from a masked result (callers narrow to their width)
  function automatic logic [LFSR_W-1:0] unmask(input logic [LFSR_W-1:0] qm,
                                               input logic [LFSR_W-1:0] mq);
    return qm ^ mq;
  endfunction

endpackage

// File: rtl/maskmul_lfsr.sv
// Free-running 32-bit Galois LFSR used as a mask source.
// Ports: clk, reset (sync, active-high, reloads seed), seed, state (current value).
module maskmul_lfsr
  import maskmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= seed;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/maskmul_share_codec.sv
// Masked-share encoder/decoder around a maskmul instance, with a result histogram.
// Ports: clk/reset; in_valid/in_ready/in_a/in_b/mask_en plaintext input;
// am/bm/ma/mb/mq shares and masks to maskmul; qm masked result back;
// out_valid/out_q/out_a/out_b plaintext result; hist_clr/hist_sel/hist_count/
// hist_total histogram control and readout.
module maskmul_share_codec
  import maskmul_pkg::*;
#(
  parameter int unsigned       W         = W_DEF,
  parameter int unsigned       DUT_LAT   = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             mask_en,
  output logic [W-1:0]     am,
  output logic [W-1:0]     bm,
  output logic [W-1:0]     ma,
  output logic [W-1:0]     mb,
  output logic [W-1:0]     mq,
  input  logic [W-1:0]     qm,
  output logic             out_valid,
  output logic [W-1:0]     out_q,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  input  logic             hist_clr,
  input  logic [W-1:0]     hist_sel,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] hist_total
);

  localparam int unsigned      DEPTH   = DUT_LAT + 1;
  localparam int unsigned      NBINS   = 1 << W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LFSR_W-1:0] lfsr_state;

  maskmul_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  // Upper LFSR bits are not needed as masks
  if (3 * W < LFSR_W) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:3*W];
  end

  logic             in_ready_q;
  logic [W-1:0]     am_q, bm_q, ma_q, mb_q, mq_q;
  logic [W-1:0]     am_d, bm_d, ma_d, mb_d, mq_d;
  logic             accept_c;

  logic             dl_vld_q [DEPTH];
  logic [W-1:0]     dl_a_q   [DEPTH];
  logic [W-1:0]     dl_b_q   [DEPTH];
  logic [W-1:0]     dl_mq_q  [DEPTH];

  logic             out_valid_q;
  logic [W-1:0]     out_q_q, out_a_q, out_b_q;
  logic [W-1:0]     out_q_d;

  logic [CNT_W-1:0] bin_q [NBINS];
  logic [CNT_W-1:0] total_q;

  assign accept_c = in_valid && in_ready_q;

  // Encode: masks come from the pre-step LFSR state; idle slots carry zeros
  always_comb begin
    ma_d = '0;
    mb_d = '0;
    mq_d = '0;
    am_d = '0;
    bm_d = '0;
    if (accept_c && mask_en) begin
      ma_d = lfsr_state[W-1:0];
      mb_d = lfsr_state[2*W-1:W];
      mq_d = lfsr_state[3*W-1:2*W];
    end
    if (accept_c) begin
      am_d = in_a ^ ma_d;
      bm_d = in_b ^ mb_d;
    end
  end

  // Decode: qm lines up with the oldest delay-line slot
  always_comb begin
    out_q_d = '0;
    if (dl_vld_q[DEPTH-1]) begin
      out_q_d = W'(unmask(LFSR_W'(qm), LFSR_W'(dl_mq_q[DEPTH-1])));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      am_q        <= '0;
      bm_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      mq_q        <= '0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_a_q[i]   <= '0;
        dl_b_q[i]   <= '0;
        dl_mq_q[i]  <= '0;
      end
    end else begin
      in_ready_q  <= 1'b1;
      am_q        <= am_d;
      bm_q        <= bm_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      mq_q        <= mq_d;
      dl_vld_q[0] <= accept_c;
      dl_a_q[0]   <= accept_c ? in_a : '0;
      dl_b_q[0]   <= accept_c ? in_b : '0;
      dl_mq_q[0]  <= mq_d;
      for (int i = 1; i < DEPTH; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_a_q[i]   <= dl_a_q[i-1];
        dl_b_q[i]   <= dl_b_q[i-1];
        dl_mq_q[i]  <= dl_mq_q[i-1];
      end
      out_valid_q <= dl_vld_q[DEPTH-1];
      out_q_q     <= out_q_d;
      out_a_q     <= dl_a_q[DEPTH-1];
      out_b_q     <= dl_b_q[DEPTH-1];
    end
  end

  // Histogram: saturating counters, clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
      total_q <= '0;
    end else if (out_valid_q) begin
      if (bin_q[out_q_q] != CNT_MAX) bin_q[out_q_q] <= bin_q[out_q_q] + CNT_W'(1);
      if (total_q != CNT_MAX)        total_q        <= total_q + CNT_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign am         = am_q;
  assign bm         = bm_q;
  assign ma         = ma_q;
  assign mb         = mb_q;
  assign mq         = mq_q;
  assign out_valid  = out_valid_q;
  assign out_q      = out_q_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign hist_count = bin_q[hist_sel];
  assign hist_total = total_q;

endmodule

// File: tb/tb_maskmul_share_codec.sv
// Self-checking bench: two codecs (CNT_W=16 and CNT_W=4) on shared stimulus,
// each closed around a one-cycle maskmul stub computing q = a & b on shares.
module tb_maskmul_share_codec;

  localparam int unsigned W    = 2;
  localparam logic [31:0] SEED = 32'hACE12461;
  localparam logic [31:0] POLY = 32'h80200003;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
  } exp_t;

  logic         clk, reset, in_valid, mask_en, hist_clr;
  logic [W-1:0] in_a, in_b, hist_sel;

  logic         in_ready, out_valid;
  logic [W-1:0] am, bm, ma, mb, mq, qm, out_q, out_a, out_b;
  logic [15:0]  hist_count, hist_total;

  logic         in_ready4, out_valid4;
  logic [W-1:0] am4, bm4, ma4, mb4, mq4, qm4, out_q4, out_a4, out_b4;
  logic [3:0]   hist_count4, hist_total4;

  exp_t         sb_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           n_out  = 0;
  logic [31:0]  mdl;
  logic [W-1:0] rec_ma, rec_mb, rec_mq;

  maskmul_share_codec #(.W(W), .DUT_LAT(1), .LFSR_SEED(SEED), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mask_en(mask_en),
    .am(am), .bm(bm), .ma(ma), .mb(mb), .mq(mq), .qm(qm),
    .out_valid(out_valid), .out_q(out_q), .out_a(out_a), .out_b(out_b),
    .hist_clr(hist_clr), .hist_sel(hist_sel),
    .hist_count(hist_count), .hist_total(hist_total)
  );

  maskmul_share_codec #(.W(W), .DUT_LAT(1), .LFSR_SEED(SEED), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .mask_en(mask_en),
    .am(am4), .bm(bm4), .ma(ma4), .mb(mb4), .mq(mq4), .qm(qm4),
    .out_valid(out_valid4), .out_q(out_q4), .out_a(out_a4), .out_b(out_b4),
    .hist_clr(hist_clr), .hist_sel(hist_sel),
    .hist_count(hist_count4), .hist_total(hist_total4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // maskmul stubs: latency 1, masked AND
  always @(posedge clk) begin
    qm  <= ((am ^ ma) & (bm ^ mb)) ^ mq;
    qm4 <= ((am4 ^ ma4) & (bm4 ^ mb4)) ^ mq4;
  end

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Reference LFSR following the same reset/step schedule
  always @(posedge clk) mdl <= reset ? SEED : lstep(mdl);

  // Scoreboard: every out_valid must match the oldest accepted operand pair
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_valid with q=%0d a=%0d b=%0d, required none", out_q, out_a, out_b);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_out++;
        if ({out_q, out_a, out_b} !== {e.q, e.a, e.b}) begin
          n_fail++;
          $display("FAIL sb_result: q/a/b=%0d/%0d/%0d, required %0d/%0d/%0d", out_q, out_a, out_b, e.q, e.a, e.b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic me);
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    mask_en  = me;
    if (in_ready === 1'b1) begin
      e.a = a; e.b = b; e.q = a & b;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_a = 2'd1; in_b = 2'd2; mask_en = 1'b1;
    hist_clr = 1'b0; hist_sel = '0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
      n_cmp++;
      if ({am, bm, ma, mb, mq, out_q, out_a, out_b} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h, required 0", {am, bm, ma, mb, mq, out_q, out_a, out_b});
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    end
    n_cmp++;
    if (hist_total !== 16'd0) begin n_fail++; $display("FAIL reset_total: got %0d, required 0", hist_total); end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, required 1", in_ready); end
  endtask

  task automatic test_unmasked();
    drive(2'd2, 2'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({am, bm, ma, mb, mq} !== {2'd2, 2'd3, 2'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL unmasked_shares: am/bm/ma/mb/mq=%0d/%0d/%0d/%0d/%0d, required 2/3/0/0/0", am, bm, ma, mb, mq);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unmasked_early: out_valid=%b, required 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_q, out_a, out_b} !== {1'b1, 2'd2, 2'd2, 2'd3}) begin
      n_fail++;
      $display("FAIL unmasked_out: v/q/a/b=%b/%0d/%0d/%0d, required 1/2/2/3", out_valid, out_q, out_a, out_b);
    end
    @(negedge clk);
  endtask

  task automatic test_masked();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rec_ma = mdl[1:0]; rec_mb = mdl[3:2]; rec_mq = mdl[5:4];
    drive(2'd2, 2'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({ma, mb, mq} !== {rec_ma, rec_mb, rec_mq}) begin
      n_fail++;
      $display("FAIL masked_masks: ma/mb/mq=%0d/%0d/%0d, required %0d/%0d/%0d", ma, mb, mq, rec_ma, rec_mb, rec_mq);
    end
    n_cmp++;
    if ({am ^ ma, bm ^ mb} !== {2'd2, 2'd3}) begin
      n_fail++;
      $display("FAIL masked_shares: am^ma=%0d bm^mb=%0d, required 2 and 3", am ^ ma, bm ^ mb);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_q} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL masked_out: v/q=%b/%0d, required 1/2", out_valid, out_q);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, ea, eb, eq, prev_mq;
    int           out0, sum;
    bit           mq_varies;
    mq_varies = 1'b0;
    prev_mq   = '0;
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      a  = W'($urandom_range(0, 3));
      b  = W'($urandom_range(0, 3));
      ea = mdl[1:0]; eb = mdl[3:2]; eq = mdl[5:4];
      drive(a, b, 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({ma, mb, mq, am ^ ma, bm ^ mb} !== {ea, eb, eq, a, b}) begin
        n_fail++;
        $display("FAIL b2b_shares[%0d]: ma/mb/mq/a/b=%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                 i, ma, mb, mq, am ^ ma, bm ^ mb, ea, eb, eq, a, b);
      end
      if (i > 0 && mq !== prev_mq) mq_varies = 1'b1;
      prev_mq = mq;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_out - out0 != 1000 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d pending=%0d, required 1000 and 0", n_out - out0, sb_q.size());
    end
    n_cmp++;
    if (mq_varies !== 1'b1) begin n_fail++; $display("FAIL b2b_mq_const: mq varied=%b, required 1", mq_varies); end
    n_cmp++;
    if (hist_total !== 16'd1000) begin n_fail++; $display("FAIL b2b_total: got %0d, required 1000", hist_total); end
    sum = 0;
    for (int s = 0; s < 4; s++) begin
      hist_sel = W'(s);
      #1;
      sum += int'(hist_count);
    end
    n_cmp++;
    if (sum != 1000) begin n_fail++; $display("FAIL b2b_bin_sum: got %0d, required 1000", sum); end
  endtask

  task automatic test_saturation();
    bit got;
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(2'd3, 2'd1, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    hist_sel = 2'd1;
    #1;
    n_cmp++;
    if ({hist_count4, hist_total4} !== {4'd15, 4'd15}) begin
      n_fail++;
      $display("FAIL sat_cnt4: bin1=%0d total=%0d, required 15 and 15", hist_count4, hist_total4);
    end
    n_cmp++;
    if ({hist_count, hist_total} !== {16'd20, 16'd20}) begin
      n_fail++;
      $display("FAIL sat_cnt16: bin1=%0d total=%0d, required 20 and 20", hist_count, hist_total);
    end
    drive(2'd1, 2'd1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL clr_wait: out_valid seen=%b, required 1", got); end
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    #1;
    n_cmp++;
    if ({hist_count, hist_total, hist_count4, hist_total4} !== '0) begin
      n_fail++;
      $display("FAIL clr_priority: bin1=%0d total=%0d bin1_4=%0d total_4=%0d, required all 0",
               hist_count, hist_total, hist_count4, hist_total4);
    end
  endtask

  task automatic test_reset_in_flight();
    int out0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(2'd2, 2'd3, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({ma, mb, mq} !== {rec_ma, rec_mb, rec_mq}) begin
      n_fail++;
      $display("FAIL restart_masks: ma/mb/mq=%0d/%0d/%0d, required %0d/%0d/%0d", ma, mb, mq, rec_ma, rec_mb, rec_mq);
    end
    drive(2'd1, 2'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    sb_q.delete();
    out0 = n_out;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_valid: got %b, required 0", out_valid); end
    end
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      hist_sel = W'(s);
      #1;
      n_cmp++;
      if (hist_count !== 16'd0) begin n_fail++; $display("FAIL inflight_bin%0d: got %0d, required 0", s, hist_count); end
    end
    n_cmp++;
    if (hist_total !== 16'd0 || n_out != out0) begin
      n_fail++;
      $display("FAIL inflight_total: total=%0d results=%0d, required 0 and 0", hist_total, n_out - out0);
    end
    @(negedge clk);
    drive(2'd2, 2'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({ma, mb, mq} !== {rec_ma, rec_mb, rec_mq}) begin
      n_fail++;
      $display("FAIL restart_masks2: ma/mb/mq=%0d/%0d/%0d, required %0d/%0d/%0d", ma, mb, mq, rec_ma, rec_mb, rec_mq);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_q} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL restart_out: v/q=%b/%0d, required 1/2", out_valid, out_q);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unmasked();
    test_masked();
    test_back_to_back();
    test_saturation();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
